// File: rtl/mac_via_if.sv
// Peripheral bus between the fx68k glue and the VIA register responder.
// One stb pulse per bus cycle; rw selects read (1) or write (0), dout is registered.
interface mac_via_if;
    logic       stb;
    logic       rw;
    logic [3:0] rs;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (output stb, output rw, output rs, output din, input dout);
    modport slave  (input stb, input rw, input rs, input din, output dout);
endinterface

// File: rtl/mac_via.sv
// Mac 128 VIA (6522 subset): port A/B registers, timers T1/T2, IFR/IER interrupt
// logic with CA1/CA2 edge inputs and a registered active-low interrupt request.
module mac_via #(
    parameter logic [15:0] c_t1_reset = 16'h0000,
    parameter logic [15:0] c_t2_reset = 16'h0000
) (
    input  logic       clk,
    input  logic       reset_n,
    mac_via_if.slave   bus,
    input  logic       e_tick,
    input  logic       ca1,
    input  logic       ca2,
    input  logic [7:0] pa_in,
    input  logic [7:0] pb_in,
    output logic [7:0] pa_out,
    output logic [7:0] pb_out,
    output logic [7:0] pa_oe,
    output logic [7:0] pb_oe,
    output logic       irq_n
);

    localparam logic [6:0] c_ifr_mask = 7'b110_0011;

    logic [7:0]  r_orb, r_ora, r_ddrb, r_ddra, r_sr, r_acr, r_pcr;
    logic [6:0]  r_ifr, r_ier;
    logic [15:0] r_t1c, r_t2c;
    logic [7:0]  r_t1l_l, r_t1l_h, r_t2l;
    logic        r_t1_armed, r_t2_armed;
    logic [7:0]  r_dout;
    logic        r_irq_n;
    logic        r_ca1_s1, r_ca1_s2, r_ca1_d;
    logic        r_ca2_s1, r_ca2_s2, r_ca2_d;

    logic       w_wr, w_rd;
    logic       w_t1_load, w_t2_load;
    logic       w_t1_uf, w_t2_uf;
    logic       w_ca1_edge, w_ca2_edge;
    logic       w_irq;
    logic [6:0] w_ifr_set, w_ifr_clr, w_ifr_next;
    logic [7:0] w_rd_data;

    assign w_wr      = bus.stb & ~bus.rw;
    assign w_rd      = bus.stb & bus.rw;
    assign w_t1_load = w_wr && (bus.rs == 4'h5);
    assign w_t2_load = w_wr && (bus.rs == 4'h9);

    // A reload write on the same edge as a tick wins, so it also suppresses the underflow.
    assign w_t1_uf = e_tick && (r_t1c == 16'h0000) && r_t1_armed && !w_t1_load;
    assign w_t2_uf = e_tick && (r_t2c == 16'h0000) && r_t2_armed && !w_t2_load;

    // Edge polarity: control bit 0 -> falling edge, 1 -> rising edge.
    assign w_ca1_edge = (r_ca1_s2 != r_ca1_d) && (r_ca1_s2 == r_pcr[0]);
    assign w_ca2_edge = (r_ca2_s2 != r_ca2_d) && (r_ca2_s2 == r_pcr[2]);

    assign w_irq = |(r_ifr & r_ier);

    always_comb begin
        w_ifr_set    = 7'h00;
        w_ifr_set[6] = w_t1_uf;
        w_ifr_set[5] = w_t2_uf;
        w_ifr_set[1] = w_ca1_edge;
        w_ifr_set[0] = w_ca2_edge;

        w_ifr_clr = 7'h00;
        if (bus.stb && (bus.rs == 4'h1)) w_ifr_clr[1:0] = 2'b11;
        if (w_t1_load || (w_wr && bus.rs == 4'h7) || (w_rd && bus.rs == 4'h4))
            w_ifr_clr[6] = 1'b1;
        if (w_t2_load || (w_rd && bus.rs == 4'h8))
            w_ifr_clr[5] = 1'b1;
        if (w_wr && bus.rs == 4'hD)
            w_ifr_clr = w_ifr_clr | bus.din[6:0];

        // Sets are applied after clears so a same-edge event keeps its flag.
        w_ifr_next = ((r_ifr & ~w_ifr_clr) | w_ifr_set) & c_ifr_mask;
    end

    always_comb begin
        w_rd_data = 8'h00;
        case (bus.rs)
            4'h0: w_rd_data = (pb_in & ~r_ddrb) | (r_orb & r_ddrb);
            4'h1: w_rd_data = pa_in;
            4'h2: w_rd_data = r_ddrb;
            4'h3: w_rd_data = r_ddra;
            4'h4: w_rd_data = r_t1c[7:0];
            4'h5: w_rd_data = r_t1c[15:8];
            4'h6: w_rd_data = r_t1l_l;
            4'h7: w_rd_data = r_t1l_h;
            4'h8: w_rd_data = r_t2c[7:0];
            4'h9: w_rd_data = r_t2c[15:8];
            4'hA: w_rd_data = r_sr;
            4'hB: w_rd_data = r_acr;
            4'hC: w_rd_data = r_pcr;
            4'hD: w_rd_data = {w_irq, r_ifr};
            4'hE: w_rd_data = {1'b1, r_ier};
            4'hF: w_rd_data = pa_in;
            default: w_rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ca1_s1 <= 1'b0;
            r_ca1_s2 <= 1'b0;
            r_ca1_d  <= 1'b0;
            r_ca2_s1 <= 1'b0;
            r_ca2_s2 <= 1'b0;
            r_ca2_d  <= 1'b0;
        end else begin
            r_ca1_s1 <= ca1;
            r_ca1_s2 <= r_ca1_s1;
            r_ca1_d  <= r_ca1_s2;
            r_ca2_s1 <= ca2;
            r_ca2_s2 <= r_ca2_s1;
            r_ca2_d  <= r_ca2_s2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_orb  <= 8'h00;
            r_ora  <= 8'h00;
            r_ddrb <= 8'h00;
            r_ddra <= 8'h00;
            r_sr   <= 8'h00;
            r_acr  <= 8'h00;
            r_pcr  <= 8'h00;
            r_ier  <= 7'h00;
        end else if (w_wr) begin
            case (bus.rs)
                4'h0: r_orb  <= bus.din;
                4'h1: r_ora  <= bus.din;
                4'h2: r_ddrb <= bus.din;
                4'h3: r_ddra <= bus.din;
                4'hA: r_sr   <= bus.din;
                4'hB: r_acr  <= bus.din;
                4'hC: r_pcr  <= bus.din;
                4'hE: r_ier  <= bus.din[7] ? (r_ier | bus.din[6:0])
                                           : (r_ier & ~bus.din[6:0]);
                4'hF: r_ora  <= bus.din;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_t1c      <= c_t1_reset;
            r_t1l_l    <= c_t1_reset[7:0];
            r_t1l_h    <= c_t1_reset[15:8];
            r_t1_armed <= 1'b0;
        end else begin
            if (w_wr && (bus.rs == 4'h4 || bus.rs == 4'h6)) r_t1l_l <= bus.din;
            if (w_wr && (bus.rs == 4'h5 || bus.rs == 4'h7)) r_t1l_h <= bus.din;
            if (w_t1_load) begin
                r_t1c      <= {bus.din, r_t1l_l};
                r_t1_armed <= 1'b1;
            end else if (e_tick) begin
                if (r_t1c != 16'h0000) begin
                    r_t1c <= r_t1c - 16'h0001;
                end else if (r_t1_armed && r_acr[6]) begin
                    r_t1c <= {r_t1l_h, r_t1l_l};
                end else begin
                    r_t1c      <= 16'hFFFF;
                    r_t1_armed <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_t2c      <= c_t2_reset;
            r_t2l      <= 8'h00;
            r_t2_armed <= 1'b0;
        end else begin
            if (w_wr && bus.rs == 4'h8) r_t2l <= bus.din;
            if (w_t2_load) begin
                r_t2c      <= {bus.din, r_t2l};
                r_t2_armed <= 1'b1;
            end else if (e_tick) begin
                if (r_t2c != 16'h0000) begin
                    r_t2c <= r_t2c - 16'h0001;
                end else begin
                    r_t2c      <= 16'hFFFF;
                    r_t2_armed <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ifr   <= 7'h00;
            r_dout  <= 8'h00;
            r_irq_n <= 1'b1;
        end else begin
            r_ifr   <= w_ifr_next;
            r_irq_n <= ~w_irq;
            if (w_rd) r_dout <= w_rd_data;
        end
    end

    assign bus.dout = r_dout;
    assign pa_out   = r_ora;
    assign pb_out   = r_orb;
    assign pa_oe    = r_ddra;
    assign pb_oe    = r_ddrb;
    assign irq_n    = r_irq_n;

endmodule

// File: tb/tb_mac_via.sv
// Directed bench for mac_via: reset, T1 one-shot/free-run, CA1 handshake,
// port B read-back, T2 flag collision and mid-count reset.
module tb_mac_via;

    logic       clk;
    logic       reset_n;
    logic       e_tick;
    logic       ca1, ca2;
    logic [7:0] pa_in, pb_in;
    logic [7:0] pa_out, pb_out, pa_oe, pb_oe;
    logic       irq_n;
    logic [7:0] rd;

    int n_checks;
    int n_fail;

    mac_via_if bus ();

    mac_via #(.c_t1_reset(16'h0000), .c_t2_reset(16'h0000)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .e_tick  (e_tick),
        .ca1     (ca1),
        .ca2     (ca2),
        .pa_in   (pa_in),
        .pb_in   (pb_in),
        .pa_out  (pa_out),
        .pb_out  (pb_out),
        .pa_oe   (pa_oe),
        .pb_oe   (pb_oe),
        .irq_n   (irq_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.stb = 1'b1; bus.rw = 1'b0; bus.rs = a; bus.din = d;
        @(negedge clk);
        bus.stb = 1'b0;
    endtask

    task automatic wr_tick(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.stb = 1'b1; bus.rw = 1'b0; bus.rs = a; bus.din = d; e_tick = 1'b1;
        @(negedge clk);
        bus.stb = 1'b0; e_tick = 1'b0;
    endtask

    task automatic rd_reg(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.stb = 1'b1; bus.rw = 1'b1; bus.rs = a;
        @(negedge clk);
        bus.stb = 1'b0;
        d = bus.dout;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e_tick = 1'b1;
            @(negedge clk);
            e_tick = 1'b0;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        e_tick   = 1'b0;
        ca1      = 1'b1;
        ca2      = 1'b0;
        pa_in    = 8'h5A;
        pb_in    = 8'h3C;
        bus.stb  = 1'b0;
        bus.rw   = 1'b1;
        bus.rs   = 4'h0;
        bus.din  = 8'h00;
        idle(3);
        check("rst_irq_n", {7'h0, irq_n}, 8'h01);
        check("rst_dout", bus.dout, 8'h00);
        check("rst_pb_oe", pb_oe, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);
        rd_reg(4'hE, rd); check("rst_ier", rd, 8'h80);

        // T1 one-shot: latch 0003, underflow on the fourth tick
        wr(4'hE, 8'hC0);
        wr(4'h4, 8'h03);
        wr(4'h5, 8'h00);
        ticks(3);
        rd_reg(4'hD, rd); check("t1os_ifr_pre", rd, 8'h00);
        ticks(1);
        rd_reg(4'hD, rd); check("t1os_ifr", rd, 8'hC0);
        check("t1os_irq_low", {7'h0, irq_n}, 8'h00);
        rd_reg(4'h4, rd); check("t1os_t1cl", rd, 8'hFF);
        check("t1os_irq_hold", {7'h0, irq_n}, 8'h00);
        @(negedge clk);
        check("t1os_irq_rel", {7'h0, irq_n}, 8'h01);
        rd_reg(4'h5, rd); check("t1os_t1ch", rd, 8'hFF);
        ticks(4);
        rd_reg(4'hD, rd); check("t1os_no_reflag", rd, 8'h00);

        // T1 free-run: latch 0002, underflows on ticks 3, 6, 9
        wr(4'hB, 8'h40);
        wr(4'h6, 8'h02);
        wr(4'h5, 8'h00);
        rd_reg(4'h6, rd); check("t1fr_latch_l", rd, 8'h02);
        ticks(2);
        rd_reg(4'hD, rd); check("t1fr_t2", rd, 8'h00);
        ticks(1);
        rd_reg(4'hD, rd); check("t1fr_t3", rd, 8'hC0);
        wr(4'hD, 8'h40);
        rd_reg(4'hD, rd); check("t1fr_clr", rd, 8'h00);
        ticks(2);
        rd_reg(4'hD, rd); check("t1fr_t5", rd, 8'h00);
        ticks(1);
        rd_reg(4'hD, rd); check("t1fr_t6", rd, 8'hC0);
        rd_reg(4'h4, rd); check("t1fr_reload", rd, 8'h02);
        ticks(2);
        rd_reg(4'hD, rd); check("t1fr_t8", rd, 8'h00);
        ticks(1);
        rd_reg(4'hD, rd); check("t1fr_t9", rd, 8'hC0);
        wr(4'hB, 8'h00);
        wr(4'hE, 8'h7F);
        wr(4'hD, 8'h7F);
        rd_reg(4'hD, rd); check("ifr_wr_clear", rd, 8'h00);

        // CA1 falling edge with PCR0 = 0
        wr(4'hC, 8'h00);
        wr(4'hE, 8'h82);
        @(negedge clk);
        ca1 = 1'b0;
        idle(3);
        check("ca1_irq_3cyc", {7'h0, irq_n}, 8'h01);
        idle(1);
        check("ca1_irq_4cyc", {7'h0, irq_n}, 8'h00);
        rd_reg(4'hD, rd); check("ca1_ifr", rd, 8'h82);
        rd_reg(4'h1, rd); check("ca1_ora_pins", rd, 8'h5A);
        rd_reg(4'hD, rd); check("ca1_hs_clear", rd, 8'h00);
        ca1 = 1'b1;
        idle(5);
        rd_reg(4'hD, rd); check("ca1_rise_ign", rd, 8'h00);
        ca1 = 1'b0;
        idle(5);
        rd_reg(4'hF, rd); check("ca1_oraf_pins", rd, 8'h5A);
        rd_reg(4'hD, rd); check("ca1_nohs_keep", rd, 8'h82);
        wr(4'hD, 8'h02);

        // Port B / port A / SR storage
        wr(4'h2, 8'h0F);
        wr(4'h0, 8'hA5);
        rd_reg(4'h0, rd); check("irb_mix", rd, 8'h35);
        check("pb_out", pb_out, 8'hA5);
        check("pb_oe", pb_oe, 8'h0F);
        wr(4'h3, 8'hF0);
        wr(4'hF, 8'h12);
        check("pa_oe", pa_oe, 8'hF0);
        check("pa_out", pa_out, 8'h12);
        wr(4'hA, 8'h3C);
        rd_reg(4'hA, rd); check("sr_rw", rd, 8'h3C);

        // T2 underflow collides with an IFR clear of bit 5
        wr(4'h8, 8'h00);
        wr(4'h9, 8'h00);
        wr_tick(4'hD, 8'h20);
        rd_reg(4'hD, rd); check("t2_collide", rd, 8'h20);
        rd_reg(4'h9, rd); check("t2_wrap_h", rd, 8'hFF);
        rd_reg(4'h8, rd); check("t2_rd_l", rd, 8'hFF);
        rd_reg(4'hD, rd); check("t2_rd_clear", rd, 8'h00);
        wr(4'hE, 8'h7F);
        rd_reg(4'hE, rd); check("ier_clear_all", rd, 8'h80);

        // Reset in the middle of a free-running count with IRQ asserted
        wr(4'hB, 8'h40);
        wr(4'hE, 8'hC0);
        wr(4'h6, 8'h01);
        wr(4'h5, 8'h00);
        ticks(2);
        idle(1);
        check("pre_rst_irq", {7'h0, irq_n}, 8'h00);
        ticks(1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_irq_n", {7'h0, irq_n}, 8'h01);
        check("mid_rst_dout", bus.dout, 8'h00);
        check("mid_rst_pa_oe", pa_oe, 8'h00);
        check("mid_rst_pb_oe", pb_oe, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        rd_reg(4'hE, rd); check("mid_rst_ier", rd, 8'h80);
        ticks(3);
        rd_reg(4'hD, rd); check("mid_rst_disarm", rd, 8'h00);
        rd_reg(4'hB, rd); check("mid_rst_acr", rd, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
